// File: rtl/fetch_unit_pkg.sv
// Shared CPU package: opcode constants, instruction field positions,
// the fetch FSM state type and a branch-opcode decode helper.
package fetch_unit_pkg;

    // Opcodes
    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000001;
    localparam logic [5:0] OP_BNE = 6'b100001;
    localparam logic [5:0] OP_BLT = 6'b100010;
    localparam logic [5:0] OP_BLE = 6'b100011;

    // Instruction field positions and widths
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS_MSB  = 20;
    localparam int RS_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

    // Fetch FSM states
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    // Conditional branches are opcodes 1000xx with xx != 00.
    function automatic logic is_branch(input logic [OPC_W-1:0] opc);
        return (opc == OP_BNE) || (opc == OP_BLT) || (opc == OP_BLE);
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// next_pc_logic: purely combinational next-PC computation.
// Ports:
//   pc          in  16  address of the instruction in ir
//   ir          in  32  current instruction
//   take_branch in  1   branch condition (only meaningful for branch opcodes)
//   next_pc     out 16  pc+1, or pc+1+imm for J / taken branches (wrapping)
module next_pc_logic #(
    parameter logic [5:0] OP_J = fetch_unit_pkg::OP_J
) (
    input  logic [15:0] pc,
    input  logic [31:0] ir,
    input  logic        take_branch,
    output logic [15:0] next_pc
);
    import fetch_unit_pkg::*;

    logic [OPC_W-1:0] opcode;
    logic [IMM_W-1:0] imm;
    logic [15:0]      seq_pc;
    logic [15:0]      target_pc;
    logic             redirect;
    logic             unused_fields;

    assign opcode    = ir[OPC_MSB:OPC_LSB];
    assign imm       = ir[IMM_MSB:IMM_LSB];
    // Register fields are decoded downstream, not here.
    assign unused_fields = ^{ir[RD_MSB:RD_LSB], ir[RS_MSB:RS_LSB]};

    // imm is full PC width, so adding it modulo 2^16 already behaves as a
    // signed displacement.
    assign seq_pc    = pc + 16'd1;
    assign target_pc = seq_pc + imm;

    // take_branch only matters for conditional branch opcodes; J is always taken.
    assign redirect  = (opcode == OP_J) || (is_branch(opcode) && take_branch);
    assign next_pc   = redirect ? target_pc : seq_pc;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the multicycle CPU.
// Owns the PC, drives the instruction-memory address, latches the returned
// word into ir and holds it until the controller signals done, then advances
// the PC (sequential, J or taken branch) and counts the retired instruction.
// Ports:
//   clk, rst      clock / synchronous active-high reset
//   imem_pc       out 16  instruction memory address (== pc)
//   imem_instr    in  32  instruction word for imem_pc
//   ir, ir_valid  out     latched instruction and its valid flag
//   pc, pc_plus1  out 16  address of ir and its successor
//   done          in  1   controller finished ir (honoured only in HOLD)
//   take_branch   in  1   branch condition, sampled with done
//   retired       out     retired-instruction count (wrapping)
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [5:0]  OP_J     = fetch_unit_pkg::OP_J,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [15:0]      imem_pc,
    input  logic [31:0]      imem_instr,
    output logic [31:0]      ir,
    output logic             ir_valid,
    output logic [15:0]      pc,
    output logic [15:0]      pc_plus1,
    input  logic             done,
    input  logic             take_branch,
    output logic [CNT_W-1:0] retired
);
    import fetch_unit_pkg::*;

    fetch_state_t     state_reg, state_next;
    logic [15:0]      pc_reg, pc_next;
    logic [31:0]      ir_reg, ir_next;
    logic             ir_valid_reg, ir_valid_next;
    logic [CNT_W-1:0] retired_reg, retired_next;
    logic [15:0]      branch_pc;

    next_pc_logic #(
        .OP_J (OP_J)
    ) u_next_pc (
        .pc          (pc_reg),
        .ir          (ir_reg),
        .take_branch (take_branch),
        .next_pc     (branch_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= FETCH;
            pc_reg       <= RESET_PC;
            ir_reg       <= 32'd0;
            ir_valid_reg <= 1'b0;
            retired_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
            ir_valid_reg <= ir_valid_next;
            retired_reg  <= retired_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ir_next       = ir_reg;
        ir_valid_next = ir_valid_reg;
        retired_next  = retired_reg;
        case (state_reg)
            FETCH: begin
                // Memory is combinational from imem_pc, so one cycle suffices.
                // done is ignored here: nothing is in flight yet.
                ir_next       = imem_instr;
                ir_valid_next = 1'b1;
                state_next    = HOLD;
            end
            HOLD: begin
                if (done) begin
                    pc_next       = branch_pc;
                    retired_next  = retired_reg + CNT_W'(1);
                    ir_valid_next = 1'b0;
                    state_next    = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    assign imem_pc  = pc_reg;
    assign pc       = pc_reg;
    assign pc_plus1 = pc_reg + 16'd1;
    assign ir       = ir_reg;
    assign ir_valid = ir_valid_reg;
    assign retired  = retired_reg;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 1: default reset PC ----------------
    logic        rst, done, take_branch;
    logic [15:0] imem_pc, pc, pc_plus1;
    logic [31:0] imem_instr, ir;
    logic        ir_valid;
    logic [15:0] retired;

    logic [31:0] mem [0:65535];
    assign imem_instr = mem[imem_pc];

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_pc     (imem_pc),
        .imem_instr  (imem_instr),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .pc          (pc),
        .pc_plus1    (pc_plus1),
        .done        (done),
        .take_branch (take_branch),
        .retired     (retired)
    );

    // ---------------- DUT 2: reset PC 0xFFFF, 2-bit counter ----------------
    logic        rst2, done2, tb2;
    logic [15:0] imem_pc2, pc2, pc_plus1_2;
    logic [31:0] imem_instr2, ir2;
    logic        ir_valid2;
    logic [1:0]  retired2;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd3, 5'd4, imm};
    endfunction

    always_comb begin
        imem_instr2 = 32'd0;
        case (imem_pc2)
            16'hFFFF: imem_instr2 = mk(6'b000110, 16'h0040);
            16'h0000: imem_instr2 = mk(6'b001000, 16'h0100);
            16'h0001: imem_instr2 = mk(6'b100010, 16'hFFFC);
            default:  imem_instr2 = 32'd0;
        endcase
    end

    fetch_unit #(
        .RESET_PC (16'hFFFF),
        .CNT_W    (2)
    ) dut2 (
        .clk         (clk),
        .rst         (rst2),
        .imem_pc     (imem_pc2),
        .imem_instr  (imem_instr2),
        .ir          (ir2),
        .ir_valid    (ir_valid2),
        .pc          (pc2),
        .pc_plus1    (pc_plus1_2),
        .done        (done2),
        .take_branch (tb2),
        .retired     (retired2)
    );

    // ---------------- checking infrastructure ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] pc;
        logic [31:0] instr;
        logic        tb;
        logic [15:0] exp_next;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] ir;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int which);
        for (int k = 0; k < 4; k++) begin
            if ((which == 1 ? ir_valid : ir_valid2) == 1'b1) break;
            tick();
        end
        check("ir_valid_rise", {31'd0, (which == 1 ? ir_valid : ir_valid2)}, 32'd1);
    endtask

    // One retire on DUT 2: wait for the fetch, pulse done, check the new PC.
    task automatic step2(input logic br, input logic [15:0] exp_pc, input logic [1:0] exp_ret);
        wait_valid(2);
        done2 = 1'b1;
        tb2   = br;
        tick();
        done2 = 1'b0;
        tb2   = 1'b0;
        check("dut2_pc", {16'd0, pc2}, {16'd0, exp_pc});
        check("dut2_retired", {30'd0, retired2}, {30'd0, exp_ret});
        $display("dut2 retire -> pc=%h retired=%0d", pc2, retired2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (n_vec %0d)", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        sb_t         got;
        logic [31:0] held_ir;
        logic [15:0] held_pc;

        // Program walk: {pc, instr, take_branch, expected next pc}
        vecs[0]  = '{16'd0,  32'hE4270007,             1'b0, 16'd1};
        vecs[1]  = '{16'd1,  mk(6'b000100, 16'h1234),  1'b0, 16'd2};
        vecs[2]  = '{16'd2,  mk(6'b100000, 16'h0005),  1'b1, 16'd3};   // 1000_00 is not a branch
        vecs[3]  = '{16'd3,  32'h0000_0000,            1'b0, 16'd4};   // NOP retires normally
        vecs[4]  = '{16'd4,  mk(6'b010000, 16'h0009),  1'b1, 16'd5};
        vecs[5]  = '{16'd5,  mk(6'b000001, 16'h0006),  1'b0, 16'd12};  // J
        vecs[6]  = '{16'd12, mk(6'b100001, 16'hFFFD),  1'b0, 16'd13};  // BNE not taken
        vecs[7]  = '{16'd13, mk(6'b000001, 16'hFFFE),  1'b0, 16'd12};  // J backwards
        vecs[8]  = '{16'd12, mk(6'b100001, 16'hFFFD),  1'b1, 16'd10};  // BNE taken
        vecs[9]  = '{16'd10, mk(6'b000001, 16'h0007),  1'b1, 16'd18};  // J, tb ignored
        vecs[10] = '{16'd18, mk(6'b000001, 16'h0002),  1'b0, 16'd21};  // J, tb=0
        vecs[11] = '{16'd21, mk(6'b100010, 16'h0010),  1'b1, 16'd38};  // BLT taken
        vecs[12] = '{16'd38, mk(6'b100011, 16'h0005),  1'b0, 16'd39};  // BLE not taken
        vecs[13] = '{16'd39, mk(6'b100011, 16'h0100),  1'b1, 16'd296}; // BLE taken

        for (int a = 0; a < 65536; a++) mem[a] = 32'd0;
        foreach (vecs[i]) mem[vecs[i].pc] = vecs[i].instr;
        mem[296] = mk(6'b011000, 16'hABCD);

        rst = 1'b1; done = 1'b0; take_branch = 1'b0;
        rst2 = 1'b1; done2 = 1'b0; tb2 = 1'b0;
        tick();
        tick();
        check("reset_pc", {16'd0, pc}, 32'd0);
        check("reset_ir", ir, 32'd0);
        check("reset_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("reset_retired", {16'd0, retired}, 32'd0);
        rst = 1'b0;

        // ---------------- table-driven program walk ----------------
        foreach (vecs[i]) begin
            sb_q.push_back('{vecs[i].pc, vecs[i].instr});
            check("fetch_ir_valid_low", {31'd0, ir_valid}, 32'd0);
            check("imem_pc", {16'd0, imem_pc}, {16'd0, vecs[i].pc});
            wait_valid(1);
            got = sb_q.pop_front();
            check("hold_pc", {16'd0, pc}, {16'd0, got.pc});
            check("hold_ir", ir, got.ir);
            check("pc_plus1", {16'd0, pc_plus1}, {16'd0, got.pc + 16'd1});
            done        = 1'b1;
            take_branch = vecs[i].tb;
            tick();
            done        = 1'b0;
            take_branch = 1'b0;
            check("next_pc", {16'd0, pc}, {16'd0, vecs[i].exp_next});
            check("retire_ir_valid", {31'd0, ir_valid}, 32'd0);
            check("retired", {16'd0, retired}, i + 1);
            $display("vec %0d: pc %h instr %h tb %0d -> pc %h retired %0d",
                     i, got.pc, got.ir, vecs[i].tb, pc, retired);
        end

        // ---------------- done during FETCH is ignored ----------------
        done = 1'b1;
        tick();
        done = 1'b0;
        check("fetch_done_retired", {16'd0, retired}, 32'd14);
        check("fetch_done_pc", {16'd0, pc}, 32'd296);
        check("fetch_done_ir", ir, mem[296]);
        check("fetch_done_valid", {31'd0, ir_valid}, 32'd1);
        $display("done in FETCH: pc %h retired %0d", pc, retired);

        // ---------------- HOLD with done low for 7 cycles ----------------
        held_ir = mem[296];
        held_pc = 16'd296;
        for (int c = 0; c < 7; c++) begin
            tick();
            check("stall_ir", ir, held_ir);
            check("stall_pc", {16'd0, pc}, {16'd0, held_pc});
            check("stall_valid", {31'd0, ir_valid}, 32'd1);
        end
        $display("stall 7 cycles: pc %h ir %h", pc, ir);

        // ---------------- reset in HOLD with done on the same edge ----------------
        rst  = 1'b1;
        done = 1'b1;
        tick();
        rst  = 1'b0;
        done = 1'b0;
        check("midrst_pc", {16'd0, pc}, 32'd0);
        check("midrst_ir", ir, 32'd0);
        check("midrst_valid", {31'd0, ir_valid}, 32'd0);
        check("midrst_retired", {16'd0, retired}, 32'd0);
        tick();
        check("restart_valid", {31'd0, ir_valid}, 32'd1);
        check("restart_ir", ir, 32'hE4270007);
        $display("reset in HOLD: restart ir %h valid %0d", ir, ir_valid);

        // ---------------- wrap-around on DUT 2 ----------------
        tick();
        rst2 = 1'b0;
        check("dut2_reset_pc", {16'd0, pc2}, 32'h0000FFFF);
        check("dut2_pc_plus1", {16'd0, pc_plus1_2}, 32'd0);
        step2(1'b0, 16'h0000, 2'd1);  // sequential wrap FFFF -> 0000
        step2(1'b0, 16'h0001, 2'd2);
        step2(1'b1, 16'hFFFE, 2'd3);  // BLT at 1, imm FFFC taken
        wait_valid(2);
        check("dut2_nop_ir", ir2, 32'd0);
        done2 = 1'b1;
        tick();
        done2 = 1'b0;
        check("dut2_pc_nop", {16'd0, pc2}, 32'h0000FFFF);
        check("dut2_retired_wrap", {30'd0, retired2}, 32'd0);
        $display("dut2 retire NOP -> pc=%h retired=%0d", pc2, retired2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the multicycle CPU. Sits directly upstream of the instruction memory: owns the 16-bit PC and drives the memory address.
- Latches the returned 32-bit word into an instruction register and holds it stable for the decode/execute controller until that controller signals completion.
- Computes the next PC: sequential, J (relative), or taken branch (relative).
- Keeps a retired-instruction counter for bench and debug visibility.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- OP_J, 6'b000001, opcode of the unconditional relative jump.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_pc  out  16  address to instruction memory; always equals pc.
- imem_instr  in  32  instruction word from memory; combinational from imem_pc.
- ir  out  32  latched instruction register.
- ir_valid  out  1  ir holds a fetched instruction that has not been retired.
- pc  out  16  address of the instruction in ir.
- pc_plus1  out  16  pc+1, mod 2^16.
- done  in  1  controller finished executing ir; sampled only while ir_valid=1.
- take_branch  in  1  branch condition true; sampled together with done.
- retired  out  CNT_W  number of instructions retired since reset.

Behaviour:
- Reset (rst=1 at posedge): state=FETCH, pc=RESET_PC, ir=0, ir_valid=0, retired=0. rst has priority over all other inputs.
- Instruction fields: opcode=ir[31:26], rd=ir[25:21], rs=ir[20:16], imm=ir[15:0]. Branch opcodes are 100001 (BNE), 100010 (BLT) and 100011 (BLE), i.e. ir[31:28]==4'b1000 and ir[27:26]!=0.
- FSM has two states:
  - FETCH: imem_pc=pc. At the posedge, ir<=imem_instr, ir_valid<=1, state<=HOLD. FETCH always lasts exactly 1 cycle.
  - HOLD: ir, pc and ir_valid stay stable while done=0.
  - HOLD with done=1 at a posedge: pc<=next_pc, retired<=retired+1, ir_valid<=0, state<=FETCH.
- next_pc, all arithmetic 16-bit and wrapping:
  - opcode==OP_J: pc+1+imm. take_branch is ignored.
  - branch opcode with take_branch=1: pc+1+imm.
  - all other cases: pc+1. take_branch is ignored for non-branch opcodes.
  - imm is 16 bits, so the sign extension is implicit. Example: PC 12, imm 16'hFFFD gives next_pc 10.
- Latency: 2 cycles per instruction minimum (FETCH + 1 HOLD cycle with done=1). ir_valid rises 1 cycle after entering FETCH.
- done asserted while ir_valid=0 (i.e. in FETCH) is ignored; no retire, no PC change.
- Wrap-around:
  - pc=16'hFFFF sequential → 16'h0000.
  - Branch/jump targets wrap mod 2^16.
  - retired wraps from all-ones to 0.
- An all-zero ir (NOP / out-of-program fill) retires like any other instruction. The fetch unit never halts on its own.
- rst asserted mid-HOLD or mid-FETCH discards ir contents on the next posedge (ir=0, ir_valid=0, pc=RESET_PC).
- pc_plus1 is combinational from pc; imem_pc is combinational and equals pc.

Decomposition:
- Shared CPU package holds:
  - opcode constants (OP_J, OP_BNE, OP_BLT, OP_BLE, OP_NOP=0);
  - field bit positions and widths (OPC_MSB/LSB, RD, RS, IMM);
  - FSM state enum {FETCH, HOLD}.
- One natural sub-module: next_pc_logic. It is purely combinational: (pc, ir, take_branch) → next_pc, with branch/jump decode inside. It is reused later by a branch-predict experiment.

Test Plan:
- Reset then release, memory returns 32'hE4270007 at 0, done pulsed 1 cycle in HOLD → ir=32'hE4270007 with ir_valid one cycle after release, then pc=1, retired=1.
- Sequential run of 5 non-branch words, done asserted every HOLD cycle → pc steps 0,1,2,3,4,5; ir_valid toggles 0/1 each cycle; retired=5.
- J at pc 18 with imm=2, take_branch=0 → next pc=21. BNE at pc 12 with imm 16'hFFFD: take_branch=1 → pc=10; take_branch=0 → pc=13.
- done held low for 7 cycles in HOLD → ir, pc and ir_valid are unchanged for all 7 cycles. A done pulse during FETCH is ignored (retired unchanged).
- Wrap: RESET_PC=16'hFFFF, sequential instruction → pc=16'h0000. Branch at pc 1 with imm 16'hFFFC taken → pc=16'hFFFE.
- rst asserted in HOLD with done=1 on the same edge → pc=RESET_PC, ir=0, ir_valid=0, retired=0; fetch restarts on the next cycle.
